// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the RV32I hazard/sequencing logic.
// Decode bundle, sequencer states and the x0 register constant.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_DRAIN,
        HZ_FLUSH
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rd;
        logic       is_load;
        logic       is_fence;
    } hzDecPkt;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Load scoreboard: pending-destination vector, in-flight load count,
// and busy lookups with same-cycle wakeup from the returning load.
module pipe_hazard_ctrl_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic        ret_valid,
    input  logic [4:0]  ret_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic        full,
    output logic [31:0] pending,
    output logic [3:0]  outstanding
);

    logic [31:0] pending_d;
    logic        ret_ok;

    // A return with nothing in flight is a protocol error and is dropped.
    assign ret_ok = ret_valid & (outstanding != 4'd0);

    assign rs1_busy = (q_rs1 != REG_X0) & pending[q_rs1]
                    & ~(ret_valid & (ret_rd == q_rs1));
    assign rs2_busy = (q_rs2 != REG_X0) & pending[q_rs2]
                    & ~(ret_valid & (ret_rd == q_rs2));
    assign rd_busy  = (q_rd != REG_X0) & pending[q_rd]
                    & ~(ret_valid & (ret_rd == q_rd));

    assign full = (outstanding == 4'(MAX_OUTSTANDING));

    always_comb begin
        pending_d = pending;
        if (ret_ok)
            pending_d[ret_rd] = 1'b0;
        if (ld_issue && (ld_rd != REG_X0))
            pending_d[ld_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending <= pending_d;
            unique case ({ld_issue, ret_ok})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RAW/WAW/capacity stalls, redirect flush, FENCE drain.
// Optional HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        decValid_i,
    input  logic [4:0]  decRs1_i,
    input  logic [4:0]  decRs2_i,
    input  logic        decUseRs1_i,
    input  logic        decUseRs2_i,
    input  logic [4:0]  decRd_i,
    input  logic        decIsLoad_i,
    input  logic        decIsFence_i,
    input  logic        ldRetValid_i,
    input  logic [4:0]  ldRetRd_i,
    input  logic        redirect_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        issue_o,
    output logic [31:0] pending_o,
    output logic [3:0]  outstanding_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stallCnt_o,
    output logic [31:0] flushCnt_o
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    hzDecPkt   dec;
    hz_state_t state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic rs1_busy, rs2_busy, rd_busy, full;
    logic raw_haz, waw_haz, cap_haz;
    logic stall, flush;

    assign dec = '{valid: decValid_i, rs1: decRs1_i, rs2: decRs2_i,
                   use_rs1: decUseRs1_i, use_rs2: decUseRs2_i,
                   rd: decRd_i, is_load: decIsLoad_i,
                   is_fence: decIsFence_i};

    pipe_hazard_ctrl_scoreboard #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .ld_issue   (issue_o & dec.is_load),
        .ld_rd      (dec.rd),
        .ret_valid  (ldRetValid_i),
        .ret_rd     (ldRetRd_i),
        .q_rs1      (dec.rs1),
        .q_rs2      (dec.rs2),
        .q_rd       (dec.rd),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_busy    (rd_busy),
        .full       (full),
        .pending    (pending_o),
        .outstanding(outstanding_o)
    );

    assign raw_haz = dec.valid & ((dec.use_rs1 & rs1_busy)
                                | (dec.use_rs2 & rs2_busy));
    assign waw_haz = dec.valid & dec.is_load & rd_busy;
    assign cap_haz = dec.valid & dec.is_load & full & ~ldRetValid_i;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            HZ_RUN: begin
                if (redirect_i) begin
                    flush   = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
                end else if (dec.valid && dec.is_fence
                             && outstanding_o != 4'd0) begin
                    stall   = 1'b1;
                    state_d = HZ_DRAIN;
                end else begin
                    stall = raw_haz | waw_haz | cap_haz;
                end
            end
            HZ_DRAIN: begin
                if (redirect_i) begin
                    flush   = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
                end else if (outstanding_o == 4'd0
                             || (outstanding_o == 4'd1 && ldRetValid_i)) begin
                    state_d = HZ_RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            HZ_FLUSH: begin
                flush = 1'b1;
                // Counter covers the cycles after the redirect cycle itself.
                if (redirect_i) begin
                    fcnt_d = FLUSH_LOAD;
                end else if (fcnt_q <= 3'd1) begin
                    fcnt_d  = 3'd0;
                    state_d = HZ_RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HZ_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign stall_o = stall & rst;
    assign flush_o = flush & rst;
    assign issue_o = dec.valid & ~stall & ~flush & rst;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_o <= '0;
            flushCnt_o <= '0;
        end else begin
            stallCnt_o <= stallCnt_o + 32'(stall_o);
            flushCnt_o <= flushCnt_o + 32'(flush_o);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Honours HAZARD_PERF_CNT_EN when the design is built with it.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        decValid_i, decUseRs1_i, decUseRs2_i;
    logic        decIsLoad_i, decIsFence_i;
    logic [4:0]  decRs1_i, decRs2_i, decRd_i, ldRetRd_i;
    logic        ldRetValid_i, redirect_i;
    logic        stall_o, flush_o, issue_o;
    logic [31:0] pending_o;
    logic [3:0]  outstanding_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCnt_o, flushCnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.MAX_OUTSTANDING(4), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .decValid_i   (decValid_i),
        .decRs1_i     (decRs1_i),
        .decRs2_i     (decRs2_i),
        .decUseRs1_i  (decUseRs1_i),
        .decUseRs2_i  (decUseRs2_i),
        .decRd_i      (decRd_i),
        .decIsLoad_i  (decIsLoad_i),
        .decIsFence_i (decIsFence_i),
        .ldRetValid_i (ldRetValid_i),
        .ldRetRd_i    (ldRetRd_i),
        .redirect_i   (redirect_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .issue_o      (issue_o),
        .pending_o    (pending_o),
        .outstanding_o(outstanding_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCnt_o   (stallCnt_o),
        .flushCnt_o   (flushCnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        decValid_i = 0; decUseRs1_i = 0; decUseRs2_i = 0;
        decIsLoad_i = 0; decIsFence_i = 0;
        decRs1_i = 0; decRs2_i = 0; decRd_i = 0;
        ldRetValid_i = 0; ldRetRd_i = 0; redirect_i = 0;
    endtask

    // Advance one clock; inputs change 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        decValid_i = 1; decIsLoad_i = 1; decRd_i = rd;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2);
        idle();
        decValid_i = 1; decRd_i = rd;
        decUseRs1_i = 1; decRs1_i = r1;
        decUseRs2_i = 1; decRs2_i = r2;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        #2;
        n_tests++;
        if ({stall_o, flush_o, issue_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 000",
                     {stall_o, flush_o, issue_o});
        end
        n_tests++;
        if (pending_o !== 32'h0 || outstanding_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_sb: got %h/%0d expected 0/0",
                     pending_o, outstanding_o);
        end
        cyc();
        rst = 1;
        cyc();
    endtask

    task automatic test_raw();
        load(5'd5); #1;
        chk("raw_ld_issue", {31'd0, issue_o}, 1);
        cyc(); alu(5'd6, 5'd5, 5'd1); #1;
        chk("raw_stall", {30'd0, stall_o, issue_o}, 32'b10);
        chk("raw_pend", pending_o, 32'h20);
        cyc(); #1;
        chk("raw_stall2", {31'd0, stall_o}, 1);
        cyc(); ldRetValid_i = 1; ldRetRd_i = 5'd5; #1;
        chk("raw_wake", {30'd0, stall_o, issue_o}, 32'b01);
        cyc(); idle(); #1;
        chk("raw_clear", pending_o, 32'h0);
        chk("raw_out0", {28'd0, outstanding_o}, 0);
    endtask

    task automatic test_x0_load();
        load(5'd0); #1;
        chk("x0_issue", {31'd0, issue_o}, 1);
        cyc(); alu(5'd6, 5'd0, 5'd0); #1;
        chk("x0_nostall", {30'd0, stall_o, issue_o}, 32'b01);
        chk("x0_pend", pending_o, 32'h0);
        chk("x0_out1", {28'd0, outstanding_o}, 1);
        cyc(); idle(); ldRetValid_i = 1; ldRetRd_i = 5'd0;
        cyc(); idle(); #1;
        chk("x0_out0", {28'd0, outstanding_o}, 0);
        ldRetValid_i = 1; ldRetRd_i = 5'd3;
        cyc(); idle(); #1;
        chk("underflow", {28'd0, outstanding_o}, 0);
    endtask

    task automatic test_cap();
        for (int i = 1; i <= 4; i++) begin
            load(5'(i)); #1;
            chk("cap_fill", {31'd0, issue_o}, 1);
            cyc();
        end
        load(5'd7); #1;
        chk("cap_stall", {31'd0, stall_o}, 1);
        chk("cap_out4", {28'd0, outstanding_o}, 4);
        cyc(); ldRetValid_i = 1; ldRetRd_i = 5'd1; #1;
        chk("cap_ret_issue", {30'd0, stall_o, issue_o}, 32'b01);
        cyc(); idle(); #1;
        chk("cap_out_hold", {28'd0, outstanding_o}, 4);
        chk("cap_pend", pending_o, 32'h9C);
        for (int i = 2; i <= 5; i++) begin
            idle(); ldRetValid_i = 1;
            ldRetRd_i = (i == 5) ? 5'd7 : 5'(i);
            cyc();
        end
        idle(); #1;
        chk("cap_drained", {28'd0, outstanding_o}, 0);
    endtask

    task automatic test_redirect();
        load(5'd5);
        cyc(); alu(5'd6, 5'd5, 5'd1); #1;
        chk("rd_rawstall", {31'd0, stall_o}, 1);
        cyc(); redirect_i = 1; #1;
        chk("rd_f1", {29'd0, flush_o, stall_o, issue_o}, 32'b100);
        cyc(); redirect_i = 0; #1;
        chk("rd_f2", {30'd0, flush_o, stall_o}, 32'b10);
        cyc(); #1;
        chk("rd_end", {30'd0, flush_o, stall_o}, 32'b01);
        cyc(); redirect_i = 1; #1;
        chk("rd2_f1", {31'd0, flush_o}, 1);
        cyc(); #1;
        chk("rd2_f2", {31'd0, flush_o}, 1);
        cyc(); redirect_i = 0; #1;
        chk("rd2_f3", {31'd0, flush_o}, 1);
        cyc(); #1;
        chk("rd2_end", {31'd0, flush_o}, 0);
        ldRetValid_i = 1; ldRetRd_i = 5'd5; #1;
        chk("rd_wake", {31'd0, issue_o}, 1);
        cyc(); idle(); #1;
        chk("rd_out0", {28'd0, outstanding_o}, 0);
    endtask

    task automatic test_fence();
        load(5'd8);
        cyc(); load(5'd9);
        cyc(); idle(); decValid_i = 1; decIsFence_i = 1; #1;
        chk("fn_out2", {28'd0, outstanding_o}, 2);
        chk("fn_stall", {30'd0, stall_o, issue_o}, 32'b10);
        cyc(); #1;
        chk("fn_drain", {31'd0, stall_o}, 1);
        cyc(); ldRetValid_i = 1; ldRetRd_i = 5'd8; #1;
        chk("fn_ret1", {31'd0, stall_o}, 1);
        cyc(); ldRetRd_i = 5'd9; #1;
        chk("fn_issue", {30'd0, stall_o, issue_o}, 32'b01);
        cyc(); ldRetValid_i = 0; #1;
        chk("fn_run", {30'd0, stall_o, issue_o}, 32'b01);
        chk("fn_out0", {28'd0, outstanding_o}, 0);
        cyc(); idle();
    endtask

    task automatic test_async_reset();
        load(5'd5);
        cyc(); idle(); redirect_i = 1;
        cyc(); redirect_i = 0; alu(5'd6, 5'd1, 5'd2); #1;
        chk("ar_flush", {31'd0, flush_o}, 1);
        chk("ar_pend", pending_o, 32'h20);
        rst = 0; #1;
        chk("ar_ctl", {29'd0, stall_o, flush_o, issue_o}, 0);
        chk("ar_pend0", pending_o, 0);
        chk("ar_out0", {28'd0, outstanding_o}, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("ar_scnt", stallCnt_o, 0);
        chk("ar_fcnt", flushCnt_o, 0);
`endif
        cyc(); rst = 1;
        cyc(); #1;
        chk("ar_after", {29'd0, stall_o, flush_o, issue_o}, 32'b001);
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_raw();
        test_x0_load();
        test_cap();
        test_redirect();
        test_fence();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
